// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier family.
//   state_e     : controller states (IDLE / RUN / DONE)
//   booth_op_e  : Booth recoding of {Q[0], q_1} into NOP / ADD / SUB
//   booth_decode: maps the two examined multiplier bits to an op
//   asr1        : one-bit arithmetic right shift of a packed {A,Q,q_1}
//                 vector whose sign bit sits at index msb (operands up to
//                 64 bits, so the vector never exceeds ASR_MAX_W bits)
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'b00,
    ADD = 2'b01,
    SUB = 2'b10
  } booth_op_e;

  localparam int unsigned ASR_MAX_W = 130;

  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   return SUB;
      2'b01:   return ADD;
      default: return NOP;
    endcase
  endfunction

  // Bits above msb are zero on entry, so the plain shift leaves msb-1..0
  // correct and only the sign bit needs to be replicated back in.
  function automatic logic [ASR_MAX_W-1:0] asr1(input logic [ASR_MAX_W-1:0] v,
                                                 input logic [7:0]           msb);
    logic [ASR_MAX_W-1:0] r;
    r      = v >> 1;
    r[msb] = v[msb];
    return r;
  endfunction

endpackage

// File: rtl/booth_alu_step.sv
// One radix-2 Booth add/subtract step (combinational, pre-shift).
//   acc_i : accumulator A, WIDTH+1 bits including guard bit
//   m_i   : sign-extended multiplicand M, WIDTH+1 bits
//   q0_i  : current multiplier LSB Q[0]
//   q_1_i : previously shifted-out multiplier bit
//   acc_o : A after the recoded add/subtract; carry-out is dropped
module booth_alu_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] acc_i,
  input  logic [WIDTH:0] m_i,
  input  logic           q0_i,
  input  logic           q_1_i,
  output logic [WIDTH:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    case (booth_decode(q0_i, q_1_i))
      ADD:     acc_o = acc_i + m_i;
      SUB:     acc_o = acc_i - m_i;
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Iterative radix-2 Booth signed multiplier, one Booth step per clock.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (aborts a running multiply)
//   start : request, accepted only while busy is low
//   a, b  : signed multiplier / multiplicand, sampled on accept
//   busy  : high from the cycle after accept through the done cycle
//   done  : one-cycle pulse, p valid from this cycle
//   p     : signed 2*WIDTH product, held until the next result
// Optional build macro BOOTH_EARLY_TERM_EN: when the remaining multiplier
// bits all equal q_1 the rest of the run is pure shifting, so it is done
// in a single barrel shift and the result comes out early.
module seq_booth_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  // {A, Q, q_1}
  localparam int VEC_W = 2 * WIDTH + 2;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH:0]     alu_acc;
  logic [VEC_W-1:0]   shifted;

  booth_alu_step #(.WIDTH(WIDTH)) u_alu (
    .acc_i (a_q),
    .m_i   (m_q),
    .q0_i  (q_q[0]),
    .q_1_i (q1_q),
    .acc_o (alu_acc)
  );

  always_comb begin
    shifted = VEC_W'(asr1(ASR_MAX_W'({alu_acc, q_q, q1_q}), 8'(VEC_W - 1)));
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic             early;
  logic [2*WIDTH:0] jump;

  always_comb begin
    rem_mask = ~({WIDTH{1'b1}} << cnt_q);
    early    = ((q_q ^ {WIDTH{q1_q}}) & rem_mask) == '0;
    jump     = $signed({a_q, q_q}) >>> cnt_q;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = '0;
          q_d     = a;
          m_d     = {b[WIDTH-1], b};
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef BOOTH_EARLY_TERM_EN
        if (early) begin
          a_d     = jump[2*WIDTH:WIDTH];
          q_d     = jump[WIDTH-1:0];
          cnt_d   = '0;
          p_d     = jump[2*WIDTH-1:0];
          state_d = DONE;
        end else
`endif
        begin
          {a_d, q_d, q1_d} = shifted;
          cnt_d            = cnt_q - CNT_W'(1);
          // Product is captured on the edge into DONE so p is valid with done.
          if (cnt_q == CNT_W'(1)) begin
            p_d     = shifted[VEC_W-2:1];
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
module tb_seq_booth_mult;

  localparam int W     = 8;
  localparam int BOUND = 40;
`ifdef BOOTH_EARLY_TERM_EN
  localparam int PIN_LAT_A0 = 2;
  localparam int PIN_LAT_A3 = 5;
`else
  localparam int PIN_LAT_A0 = 9;
  localparam int PIN_LAT_A3 = 9;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycles from the accept edge to the edge ending the done cycle.
  // Plain build: W Booth steps plus the done cycle. Early-termination build:
  // after k steps the untouched multiplier bits are a[W-1:k] and the last
  // shifted-out bit is a[k-1] (0 before any step); once those all agree only
  // shifts remain, taking one more cycle.
  function automatic int exp_lat(input logic [W-1:0] av);
    int run;
    run = W;
`ifdef BOOTH_EARLY_TERM_EN
    for (int k = 0; k < W; k++) begin
      logic prev;
      logic ok;
      prev = 1'b0;
      if (k > 0) prev = av[k-1];
      ok = 1'b1;
      for (int j = k; j < W; j++) if (av[j] != prev) ok = 1'b0;
      if (ok) begin
        run = k + 1;
        break;
      end
    end
`endif
    return run + 1;
  endfunction

  // Transaction-level model: remaining busy cycles, pending and visible product.
  int             mdl_left = 0;
  logic [2*W-1:0] mdl_pend = '0;
  logic [2*W-1:0] mdl_p    = '0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_left = 0;
      mdl_p    = '0;
    end else if (mdl_left == 0) begin
      if (start) begin
        int pa, pb;
        pa       = $signed(a);
        pb       = $signed(b);
        mdl_pend = 16'(pa * pb);
        mdl_left = exp_lat(a);
      end
    end else begin
      mdl_left--;
      if (mdl_left == 1) mdl_p = mdl_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", longint'(busy), longint'(mdl_left > 0));
      check("done", longint'(done), longint'(mdl_left == 1));
      check("p", longint'(p), longint'(mdl_p));
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input longint exp_p);
    int guard;
    int lat;
    guard = 0;
    while (busy && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < BOUND) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat(av));
    check({name, "_p"}, $signed(p), exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int ndone;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_p", longint'(p), 0);
    rst = 1'b0;
    @(negedge clk);

    // pin the latency model
    check("pin_lat_a0", exp_lat(8'd0), PIN_LAT_A0);
    check("pin_lat_a3", exp_lat(8'd3), PIN_LAT_A3);

    run_op("3x5", 8'd3, 8'd5, 15);
    check("pin_mdl_3x5", $signed(mdl_p), 15);
    run_op("m128xm128", 8'h80, 8'h80, 16384);
    check("pin_p_hex_4000", longint'(p), 16'h4000);
    run_op("m128x127", 8'h80, 8'h7F, -16256);
    check("pin_p_hex_c080", longint'(p), 16'hC080);
    run_op("127x127", 8'h7F, 8'h7F, 16129);
    run_op("127xm128", 8'h7F, 8'h80, -16256);
    run_op("m1xm1", 8'hFF, 8'hFF, 1);
    run_op("0xm7", 8'h00, 8'hF9, 0);
    run_op("1xm7", 8'h01, 8'hF9, -7);
    run_op("m128x1", 8'h80, 8'h01, -128);
    run_op("5xm128", 8'h05, 8'h80, -640);
    run_op("m3x0", 8'hFD, 8'h00, 0);

    // strided sweep, back-to-back
    for (int ai = -128; ai < 128; ai += 17) begin
      for (int bi = -128; bi < 128; bi += 13) begin
        run_op("sweep", 8'(ai), 8'(bi), longint'(ai * bi));
      end
    end

    // start held through a whole operation, operands changing mid-run
    while (busy) @(negedge clk);
    a     = 8'd7;
    b     = 8'hF7;
    start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < BOUND) begin
      if (lat == 2) begin
        a = 8'd100;
        b = 8'd100;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("hold_lat", lat, exp_lat(8'd7));
    check("hold_p", $signed(p), -63);
    @(negedge clk);

    // reset during RUN cycle 4
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_done", longint'(done), 0);
    check("abort_p", longint'(p), 0);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op("after_abort", 8'd6, 8'hFA, -36);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
